// File: rtl/player_damage_ctrl.sv
// Player damage and lives controller: merges cannon hit flags into single accepted
// hits, runs a blinking invulnerability window, and latches game over at zero lives.
module player_damage_ctrl #(
    parameter int unsigned NUM_CANNONS   = 8,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 90,
    parameter int unsigned BLINK_HALF    = 8
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [NUM_CANNONS-1:0] Phit_vec,
    input  logic                   restart,
    output logic [2:0]             lives,
    output logic                   invuln,
    output logic                   player_visible,
    output logic                   game_over,
    output logic                   hit_pulse
);

    localparam int unsigned LIVES_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [CNT_W-1:0]   INV_LAST   = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [CNT_W-1:0]   BLINK_MASK = CNT_W'(BLINK_HALF);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [LIVES_W-1:0]     lives_n;
    logic [CNT_W-1:0]       inv_cnt, inv_cnt_n;
    logic [NUM_CANNONS-1:0] phit_prev;
    logic                   new_hit;
    logic                   hit_n;
    logic                   vis_n;
    logic [CNT_W-1:0]       blink_k;

    // Any rising edge on any cannon in a frame merges into one hit.
    assign new_hit = |(Phit_vec & ~phit_prev);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= PLAY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        inv_cnt_n = inv_cnt;
        hit_n     = 1'b0;
        vis_n     = 1'b1;
        blink_k   = '0;
        if (restart) begin
            state_n   = PLAY;
            lives_n   = LIVES_INIT;
            inv_cnt_n = '0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (new_hit) begin
                        hit_n = 1'b1;
                        if (lives > LIVES_W'(1)) begin
                            lives_n   = lives - LIVES_W'(1);
                            inv_cnt_n = INV_LAST;
                            state_n   = INVULN;
                        end else begin
                            lives_n = '0;
                            state_n = GAME_OVER;
                        end
                    end
                end
                INVULN: begin
                    if (inv_cnt == '0) begin
                        state_n = PLAY;
                    end else begin
                        inv_cnt_n = inv_cnt - CNT_W'(1);
                    end
                end
                GAME_OVER: begin
                    lives_n = '0;
                end
                default: begin
                    state_n = PLAY;
                end
            endcase
        end
        // Sprite hidden for the first BLINK_HALF frames of the window, then alternates.
        blink_k = INV_LAST - inv_cnt_n;
        unique case (state_n)
            INVULN:    vis_n = |(blink_k & BLINK_MASK);
            GAME_OVER: vis_n = 1'b0;
            default:   vis_n = 1'b1;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lives          <= LIVES_INIT;
            inv_cnt        <= '0;
            phit_prev      <= '0;
            hit_pulse      <= 1'b0;
            invuln         <= 1'b0;
            game_over      <= 1'b0;
            player_visible <= 1'b1;
        end else begin
            lives          <= lives_n;
            inv_cnt        <= inv_cnt_n;
            phit_prev      <= Phit_vec;
            hit_pulse      <= hit_n;
            invuln         <= (state_n == INVULN);
            game_over      <= (state_n == GAME_OVER);
            player_visible <= vis_n;
        end
    end

endmodule

// File: tb/tb_player_damage_ctrl.sv
// Directed bench for player_damage_ctrl with default parameters
// (8 cannons, 3 lives, 90-frame invulnerability, 8-frame blink half-period).
module tb_player_damage_ctrl;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] Phit_vec;
    logic       restart;
    logic [2:0] lives;
    logic       invuln;
    logic       player_visible;
    logic       game_over;
    logic       hit_pulse;

    int total  = 0;
    int passed = 0;
    int inv_frames;

    player_damage_ctrl dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .Phit_vec       (Phit_vec),
        .restart        (restart),
        .lives          (lives),
        .invuln         (invuln),
        .player_visible (player_visible),
        .game_over      (game_over),
        .hit_pulse      (hit_pulse)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_lives, input logic e_inv,
                              input logic e_vis, input logic e_go, input logic e_hit);
        check({tag, ".lives"},   8'(lives),          8'(e_lives));
        check({tag, ".invuln"},  8'(invuln),         8'(e_inv));
        check({tag, ".visible"}, 8'(player_visible), 8'(e_vis));
        check({tag, ".go"},      8'(game_over),      8'(e_go));
        check({tag, ".hit"},     8'(hit_pulse),      8'(e_hit));
    endtask

    // Advance one frame and settle just after the active edge.
    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        Phit_vec = '0;
        restart  = 1'b0;
        repeat (2) @(posedge frame_clk);
        #1;
        check_outs("reset", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step();
        check_outs("idle", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Bit 0 held for 3 frames: one hit, 90-frame window, blink pattern.
        Phit_vec = 8'h01;
        step();
        check_outs("hit1", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        inv_frames = 1;
        for (int j = 1; j < 90; j++) begin
            step();
            if (j == 3) Phit_vec = 8'h00;
            if (invuln) inv_frames++;
            if (j == 1)  check("hit1.pulse_one", 8'(hit_pulse), 8'd0);
            if (j == 7)  check("blink.f7",  8'(player_visible), 8'd0);
            if (j == 8)  check("blink.f8",  8'(player_visible), 8'd1);
            if (j == 15) check("blink.f15", 8'(player_visible), 8'd1);
            if (j == 16) check("blink.f16", 8'(player_visible), 8'd0);
            if (j == 23) check("blink.f23", 8'(player_visible), 8'd0);
            if (j == 89) check("inv.f89",   8'(invuln), 8'd1);
        end
        step();
        check_outs("exit1", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("inv.frames", 8'(inv_frames), 8'd90);

        restart = 1'b1;
        step();
        restart = 1'b0;
        check_outs("restart1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Bits 2 and 5 rising together cost one life.
        Phit_vec = 8'h24;
        step();
        check_outs("merge", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("merge.f1", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rising edge at frame 40 of the window is ignored.
        Phit_vec = 8'h00;
        repeat (38) step();
        Phit_vec = 8'h02;
        step();
        check_outs("ignored.f40", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        Phit_vec = 8'h00;
        repeat (49) step();
        check("inv2.f89", 8'(invuln), 8'd1);
        step();
        check_outs("exit2", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Same edge on the first PLAY frame is accepted.
        Phit_vec = 8'h02;
        step();
        check_outs("after_exit", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        Phit_vec = 8'h00;
        repeat (90) step();
        check_outs("exit3", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Last life: game over, then further hits change nothing.
        Phit_vec = 8'h01;
        step();
        check_outs("gameover", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check_outs("gameover.f1", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        Phit_vec = 8'h00;
        step();
        Phit_vec = 8'h04;
        step();
        check_outs("gameover.hit", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_outs("restart2", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        Phit_vec = 8'h00;
        step();
        check_outs("restart2.f1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset at frame 20 of the window acts before any edge.
        Phit_vec = 8'h01;
        step();
        check_outs("hit4", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) step();
        check("hit4.f20", 8'(invuln), 8'd1);
        #2;
        Reset    = 1'b1;
        Phit_vec = 8'h00;
        #1;
        check_outs("async_rst", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step();
        check_outs("async_rst.f1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Restart wins over a simultaneous new hit.
        Phit_vec = 8'h10;
        restart  = 1'b1;
        step();
        check_outs("restart_vs_hit", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        restart  = 1'b0;
        step();
        check_outs("restart_vs_hit.f1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        Phit_vec = 8'h00;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/player_damage_ctrl.md
# player_damage_ctrl

Player damage and lives controller that sits directly downstream of the `enemy_cannon` instances. It merges the per-cannon `Phit` flags into single accepted hits and decrements the life count. After each hit it runs a timed invulnerability window with sprite blinking, and latches game-over when lives reach zero. Its outputs feed the sprite renderer (visibility), the HUD (lives) and the top-level game FSM (game over, hit pulse).

## Interface
Parameters:
- `NUM_CANNONS`, 8: number of `Phit` inputs, 1..16.
- `START_LIVES`, 3: lives loaded at reset and restart, 1..7.
- `INVULN_FRAMES`, 90: length of the invulnerability window in frames, 2..255.
- `BLINK_HALF`, 8: frames per blink half-period; a power of 2, 1..64.

Ports:
- `frame_clk`, in, 1: frame-rate clock; the only clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Phit_vec`, in, `NUM_CANNONS`: `Phit` from each cannon, registered in `frame_clk`. May stay high for several frames.
- `restart`, in, 1: synchronous new-game request, sampled on `frame_clk`.
- `lives`, out, 3: remaining lives.
- `invuln`, out, 1: high while hits are being ignored after damage.
- `player_visible`, out, 1: player sprite enable.
- `game_over`, out, 1: latched once lives reach 0.
- `hit_pulse`, out, 1: one frame high on each accepted hit.

## Operation
- Edge detect: `phit_prev` is registered with `Phit_vec` every frame. `new_hit` = OR-reduce(`Phit_vec` & ~`phit_prev`).
- Merging: any number of simultaneous or overlapping rising edges in one frame costs exactly one life.
- `phit_prev` updates in every state, including `INVULN` and `GAME_OVER`. A `Phit` held high through the end of invulnerability therefore never causes a second hit.
- State `PLAY`, on `new_hit`:
  - If `lives` > 1: `lives` decrements, `hit_pulse` goes to 1, `inv_cnt` loads `INVULN_FRAMES`-1, and the state goes to `INVULN`.
  - If `lives` == 1: `lives` goes to 0, `hit_pulse` goes to 1, and the state goes to `GAME_OVER`.
- State `INVULN`:
  - `new_hit` is ignored.
  - `inv_cnt` decrements each frame.
  - When `inv_cnt` == 0, the next edge returns the state to `PLAY`.
- State `GAME_OVER`: all hits are ignored and `lives` holds at 0.
- `restart`: high in any state means, on the next edge, state `PLAY`, `lives` = `START_LIVES`, `inv_cnt` = 0 and `hit_pulse` = 0. `restart` has priority over `new_hit` in the same frame.
- Outputs:
  - `invuln` = (state == `INVULN`).
  - `game_over` = (state == `GAME_OVER`).
  - Blink index k = `INVULN_FRAMES`-1-`inv_cnt`.
  - In `INVULN`, `player_visible` = bit log2(`BLINK_HALF`) of k. The sprite is hidden for the first `BLINK_HALF` frames, then alternates.
  - In `PLAY`, `player_visible` = 1. In `GAME_OVER`, `player_visible` = 0.
- Widths: `inv_cnt` is 8 bits. `lives` never underflows below 0.

## Timing
- Reset values: state `PLAY`, `lives` = `START_LIVES`, `invuln` = 0, `player_visible` = 1, `game_over` = 0, `hit_pulse` = 0, `phit_prev` = 0, `inv_cnt` = 0.
- Reset applied mid-`INVULN` or mid-`GAME_OVER` forces these values immediately. It does not wait for a clock edge.
- Latency: at the first edge where `Phit_vec` bit = 1 with `phit_prev` bit = 0, the following update together at that edge:
  - `lives`, `hit_pulse`, `invuln` (or `game_over`) and `player_visible` = 0.
- `invuln` is high for exactly `INVULN_FRAMES` frames.
- A hit whose rising edge arrives on the first `PLAY` frame after invulnerability is accepted.
- `hit_pulse` is high for exactly one frame per accepted hit and is never asserted by `restart`.
- All outputs are registered, or decoded from registered state alone, and are glitch-free for the renderer.

## Test plan
- Reset, then bit 0 of `Phit_vec` held high for 3 frames: `lives` 3→2 on the first edge, one `hit_pulse`, `invuln` = 1 for 90 frames, then `PLAY` with `lives` = 2 and no second hit.
- Bits 2 and 5 rising in the same frame: `lives` decrements by 1 only, and `hit_pulse` is high for one frame.
- New rising edge on bit 1 at frame 40 of `INVULN`: ignored, `lives` unchanged. The same rising edge arriving on the frame after `invuln` falls: `lives` decrements.
- Blink during `INVULN` with `BLINK_HALF` = 8: `player_visible` = 0 for frames 0-7, 1 for frames 8-15, 0 for frames 16-23, and 1 after exit.
- Three spaced hits from reset: `lives` 3→2→1→0. The third hit sets `game_over` = 1, `player_visible` = 0 and `invuln` = 0. Further hits change nothing. A one-frame `restart` gives `lives` = 3, `game_over` = 0.
- Asynchronous `Reset` at frame 20 of `INVULN`, and `restart` coinciding with a `new_hit`: both leave `lives` = 3, state `PLAY`, `hit_pulse` = 0.
